// File: rtl/fifo_flags_top.sv
// rtl/fifo_flags_top.sv - synchronous FIFO with registered read data, occupancy flags and sticky error flags
// Status outputs come only from the registered count; errors latch until cleared.
module fifo_flags_top #(
  parameter int BITS     = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [BITS-1:0]            data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic                       clr_flags_i,
  output logic [BITS-1:0]            data_o,
  output logic                       full_o,
  output logic                       pnding_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [BITS-1:0] mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BITS-1:0] data_q, data_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            pop_ok, push_ok;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_d      = data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    pop_ok  = pop_i && (count_q != '0);
    // A full FIFO can still take a push when the same edge frees a slot.
    push_ok = push_i && ((count_q != FULL_C) || pop_ok);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_ok) begin
        data_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      // A new error in the clearing cycle wins over the clear.
      if (push_i && !push_ok)   overflow_d = 1'b1;
      else if (clr_flags_i)     overflow_d = 1'b0;
      if (pop_i && !pop_ok)     underflow_d = 1'b1;
      else if (clr_flags_i)     underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign data_o         = data_q;
  assign count_o        = count_q;
  assign full_o         = (count_q == FULL_C);
  assign pnding_o       = (count_q != '0);
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_flags_top.sv
// tb/tb_fifo_flags_top.sv - self-checking bench for fifo_flags_top against a queue model
module tb_fifo_flags_top;

  localparam int BITS  = 32;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int AEL   = 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            push_i = 1'b0;
  logic [BITS-1:0] data_i = '0;
  logic            pop_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            clr_flags_i = 1'b0;
  logic [BITS-1:0] data_o;
  logic            full_o, pnding_o, almost_full_o, almost_empty_o;
  logic [2:0]      count_o;
  logic            overflow_o, underflow_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  logic [BITS-1:0] mq[$];
  logic [BITS-1:0] m_data = '0;
  bit              m_ovf = 1'b0;
  bit              m_unf = 1'b0;

  fifo_flags_top #(.BITS(BITS), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(push_i), .data_i(data_i), .pop_i(pop_i),
    .flush_i(flush_i), .clr_flags_i(clr_flags_i), .data_o(data_o), .full_o(full_o),
    .pnding_o(pnding_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the FIFO as a bounded queue, updated from the sampled inputs.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mq.delete();
      m_data = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (flush_i) begin
      mq.delete();
    end else begin
      bit pa, wa;
      pa = pop_i && (mq.size() > 0);
      wa = push_i && ((mq.size() < DEPTH) || pa);
      if (pa) m_data = mq.pop_front();
      if (wa) mq.push_back(data_i);
      if (push_i && !wa) m_ovf = 1'b1; else if (clr_flags_i) m_ovf = 1'b0;
      if (pop_i && !pa)  m_unf = 1'b1; else if (clr_flags_i) m_unf = 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      int n;
      n = mq.size();
      chk("m_data",  64'(data_o), 64'(m_data));
      chk("m_count", 64'(count_o), 64'(n));
      chk("m_full",  64'(full_o), 64'(n == DEPTH));
      chk("m_pnd",   64'(pnding_o), 64'(n != 0));
      chk("m_af",    64'(almost_full_o), 64'(n >= AFL));
      chk("m_ae",    64'(almost_empty_o), 64'(n <= AEL));
      chk("m_ovf",   64'(overflow_o), 64'(m_ovf));
      chk("m_unf",   64'(underflow_o), 64'(m_unf));
    end
  end

  task automatic drive(input bit p, input logic [BITS-1:0] d, input bit po, input bit f, input bit c);
    push_i = p; data_i = d; pop_i = po; flush_i = f; clr_flags_i = c;
    @(posedge clk_i);
    #1;
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; clr_flags_i = 1'b0;
  endtask

  task automatic fill4();
    drive(1, 32'hA, 0, 0, 0);
    drive(1, 32'hB, 0, 0, 0);
    drive(1, 32'hC, 0, 0, 0);
    drive(1, 32'hD, 0, 0, 0);
  endtask

  initial begin
    #12;
    chk("rst_count", 64'(count_o), 0);
    chk("rst_data",  64'(data_o), 0);
    chk("rst_ae",    64'(almost_empty_o), 1);
    chk("rst_full",  64'(full_o), 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    cmp_en = 1'b1;

    // Fill and drain
    drive(1, 32'hA, 0, 0, 0); chk("fill_c1", 64'(count_o), 1);
    drive(1, 32'hB, 0, 0, 0); chk("fill_c2", 64'(count_o), 2);
    drive(1, 32'hC, 0, 0, 0); chk("fill_c3", 64'(count_o), 3);
    chk("fill_af3", 64'(almost_full_o), 1);
    chk("fill_full3", 64'(full_o), 0);
    drive(1, 32'hD, 0, 0, 0); chk("fill_c4", 64'(count_o), 4);
    chk("fill_full4", 64'(full_o), 1);
    drive(0, 0, 1, 0, 0); chk("drain_a", 64'(data_o), 64'hA);
    drive(0, 0, 1, 0, 0); chk("drain_b", 64'(data_o), 64'hB);
    drive(0, 0, 1, 0, 0); chk("drain_c", 64'(data_o), 64'hC);
    drive(0, 0, 1, 0, 0); chk("drain_d", 64'(data_o), 64'hD);
    chk("drain_pnd", 64'(pnding_o), 0);

    // Overflow at full
    fill4();
    drive(1, 32'hE, 0, 0, 0);
    chk("ovf_count", 64'(count_o), 4);
    chk("ovf_flag", 64'(overflow_o), 1);
    drive(0, 0, 1, 0, 0); chk("ovf_pop_a", 64'(data_o), 64'hA);
    drive(0, 0, 1, 0, 0); chk("ovf_pop_b", 64'(data_o), 64'hB);
    drive(0, 0, 1, 0, 0); chk("ovf_pop_c", 64'(data_o), 64'hC);
    drive(0, 0, 1, 0, 0); chk("ovf_pop_d", 64'(data_o), 64'hD);
    chk("ovf_empty", 64'(count_o), 0);
    drive(0, 0, 0, 0, 1); chk("ovf_clr", 64'(overflow_o), 0);

    // Underflow at empty
    drive(0, 0, 1, 0, 0);
    chk("unf_hold", 64'(data_o), 64'hD);
    chk("unf_flag", 64'(underflow_o), 1);
    drive(1, 32'h5, 1, 0, 0);
    chk("unf_pp_count", 64'(count_o), 1);
    chk("unf_pp_flag", 64'(underflow_o), 1);
    chk("unf_pp_hold", 64'(data_o), 64'hD);
    drive(0, 0, 1, 0, 0); chk("unf_pop5", 64'(data_o), 64'h5);
    drive(0, 0, 0, 0, 1); chk("unf_clr", 64'(underflow_o), 0);

    // Simultaneous push/pop at full
    fill4();
    drive(1, 32'hE, 1, 0, 0);
    chk("fps_data", 64'(data_o), 64'hA);
    chk("fps_count", 64'(count_o), 4);
    chk("fps_ovf", 64'(overflow_o), 0);
    drive(0, 0, 1, 0, 0); chk("fps_b", 64'(data_o), 64'hB);
    drive(0, 0, 1, 0, 0); chk("fps_c", 64'(data_o), 64'hC);
    drive(0, 0, 1, 0, 0); chk("fps_d", 64'(data_o), 64'hD);
    drive(0, 0, 1, 0, 0); chk("fps_e", 64'(data_o), 64'hE);

    // Asynchronous reset mid-operation
    drive(0, 0, 1, 0, 0);
    drive(1, 32'h11, 0, 0, 0);
    drive(1, 32'h22, 0, 0, 0);
    chk("pre_rst_count", 64'(count_o), 2);
    chk("pre_rst_unf", 64'(underflow_o), 1);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_count", 64'(count_o), 0);
    chk("arst_data", 64'(data_o), 0);
    chk("arst_unf", 64'(underflow_o), 0);
    chk("arst_pnd", 64'(pnding_o), 0);
    chk("arst_ae", 64'(almost_empty_o), 1);
    chk("arst_af", 64'(almost_full_o), 0);
    @(negedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    drive(1, 32'h77, 0, 0, 0);
    drive(0, 0, 1, 0, 0); chk("post_rst_pop", 64'(data_o), 64'h77);

    // Flush overrides push
    fill4();
    drive(1, 32'h99, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("pre_flush_count", 64'(count_o), 3);
    drive(1, 32'h55, 0, 1, 0);
    chk("flush_count", 64'(count_o), 0);
    chk("flush_pnd", 64'(pnding_o), 0);
    chk("flush_data", 64'(data_o), 64'hA);
    chk("flush_ovf", 64'(overflow_o), 1);
    drive(0, 0, 0, 0, 1);

    // Random soak
    for (int i = 0; i < 1000; i++) begin
      drive(bit'($urandom_range(0, 99) < 55), $urandom, bit'($urandom_range(0, 99) < 50),
            bit'($urandom_range(0, 99) < 3), bit'($urandom_range(0, 99) < 6));
    end

    @(posedge clk_i); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_flags_top.md
FIFO_FLAGS_TOP -- requirements
Module: fifo_flags_top

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BITS, 32, data width in bits (>=1).
- DEPTH, 4, number of entries (power of two, >=2).
- AF_LEVEL, DEPTH-1, almost_full_o threshold.
- AE_LEVEL, 1, almost_empty_o threshold.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock; all state changes on the rising edge.
- rst_i, in, 1, asynchronous active-low reset.
- push_i, in, 1, write request.
- data_i, in, BITS, write data.
- pop_i, in, 1, read request.
- flush_i, in, 1, synchronous empty command.
- clr_flags_i, in, 1, synchronous clear of sticky error flags.
- data_o, out, BITS, registered read data.
- full_o, out, 1, count == DEPTH.
- pnding_o, out, 1, count != 0.
- almost_full_o, out, 1, count >= AF_LEVEL.
- almost_empty_o, out, 1, count <= AE_LEVEL.
- count_o, out, $clog2(DEPTH)+1, current occupancy.
- overflow_o, out, 1, sticky flag: push was rejected.
- underflow_o, out, 1, sticky flag: pop was rejected.

Function
REQ-003 Storage SHALL be a DEPTH x BITS register array with wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-004 Push SHALL be accepted when push_i=1 and (count<DEPTH, or pop is accepted in the same cycle); an accepted push writes data_i at wr_ptr and increments wr_ptr.
REQ-005 Pop SHALL be accepted when pop_i=1 and count>0; on that edge data_o SHALL load mem[rd_ptr] and rd_ptr SHALL increment (one-cycle latency from pop to data).
REQ-006 data_o SHALL hold its last value whenever no pop is accepted.
REQ-007 count SHALL update as follows: +1 on push only, -1 on pop only, unchanged when both are accepted.
REQ-008 When full, simultaneous push and pop SHALL both be accepted: data_o gets the oldest entry, the new entry is written, and count stays DEPTH.
REQ-009 When empty, simultaneous push and pop SHALL accept the push only; the pop is rejected, with no fall-through.
REQ-010 Push while full without pop SHALL be dropped: memory, pointers and count unchanged, and overflow_o set to 1 on that edge.
REQ-011 Pop while empty SHALL be ignored: data_o held and underflow_o set to 1 on that edge.
REQ-012 overflow_o and underflow_o SHALL remain 1 until clr_flags_i=1 or reset.
- If clr_flags_i and a new error occur in the same cycle, the flag SHALL remain 1.
REQ-013 flush_i=1 SHALL override push/pop on that edge:
- wr_ptr, rd_ptr and count go to 0;
- data_o and the sticky flags are unchanged;
- memory contents are don't-care.
REQ-014 Status outputs full_o, pnding_o, almost_full_o, almost_empty_o and count_o SHALL be derived combinationally from the registered count only, never from the current-cycle inputs.
REQ-015 Sizing: count SHALL be a $clog2(DEPTH)+1-bit value and SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-016 rst_i=0 SHALL immediately, independent of clk_i, force:
- pointers and count to 0;
- data_o to 0;
- overflow_o and underflow_o to 0;
- consequently full_o=0, pnding_o=0, almost_empty_o=1, almost_full_o=0.
REQ-017 Reset asserted mid-operation (any occupancy) SHALL discard all contents; the first push after rst_i returns to 1 SHALL land at entry 0.
REQ-018 Memory array contents need not be reset.

Verification (BITS=32, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-019 Fill/drain: push 0xA,0xB,0xC,0xD, then pop 4 times.
- After the fills: count_o 1,2,3,4; almost_full_o=1 at 3; full_o=1 at 4.
- data_o = 0xA,0xB,0xC,0xD, each one edge after its pop; then pnding_o=0.
REQ-020 Full overflow: at full, push 0xE alone.
- Required: count_o stays 4 and overflow_o=1.
- Subsequent pops return 0xA..0xD (0xE absent).
- clr_flags_i pulse clears overflow_o to 0.
REQ-021 Empty underflow: at empty, pop alone.
- Required: data_o holds its prior value and underflow_o=1.
- Simultaneous push 0x5 / pop: count_o=1, underflow_o=1; the next pop yields 0x5.
REQ-022 Full simultaneous: at full with 0xA..0xD stored, push 0xE together with pop.
- Required: data_o=0xA and count_o=4.
- Draining yields 0xB,0xC,0xD,0xE (wrap-around verified).
REQ-023 Reset and flush mid-operation:
- At count 2, assert rst_i=0 between clock edges: outputs go to reset values before the next edge.
- At count 3, flush_i=1 with push_i=1: count_o=0 and pnding_o=0, with data_o and flags unchanged.
REQ-024 Random soak: 1000 cycles of random push/pop/data against a queue reference model; data_o, count_o and all flags SHALL match every cycle.
